// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divisor helpers
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Nominal line rate selected by the 3-bit baud code.
    function automatic int unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            3'd0:    return 300;
            3'd1:    return 1200;
            3'd2:    return 4800;
            3'd3:    return 9600;
            3'd4:    return 19200;
            3'd5:    return 38400;
            3'd6:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Clocks per oversample tick, rounded to nearest; meant for elaboration-time use.
    function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned den;
        den = OVERSAMPLE * baud_rate(sel);
        return DIV_W'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/baud_controller.sv
// rtl/baud_controller.sv - 16x oversample strobe generator for the selected baud rate
module baud_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    // Divisors are folded to constants here so no runtime divider is built.
    localparam logic [DIV_W-1:0] DIV_TABLE [8] = '{
        baud_divisor(CLK_FREQ_HZ, 3'd0),
        baud_divisor(CLK_FREQ_HZ, 3'd1),
        baud_divisor(CLK_FREQ_HZ, 3'd2),
        baud_divisor(CLK_FREQ_HZ, 3'd3),
        baud_divisor(CLK_FREQ_HZ, 3'd4),
        baud_divisor(CLK_FREQ_HZ, 3'd5),
        baud_divisor(CLK_FREQ_HZ, 3'd6),
        baud_divisor(CLK_FREQ_HZ, 3'd7)
    };

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_max;
    logic [2:0]       sel_q;

    // Terminal count for the current rate.
    always_comb begin
        div_max = DIV_TABLE[baud_select] - DIV_W'(1);
    end

    // Free-running divider; restarts whenever the rate selection changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt       <= '0;
            sel_q         <= 3'd0;
            sample_ENABLE <= 1'b0;
        end else begin
            sel_q         <= baud_select;
            sample_ENABLE <= 1'b0;
            if (baud_select != sel_q) begin
                div_cnt <= '0;
            end else if (div_cnt == div_max) begin
                div_cnt       <= '0;
                sample_ENABLE <= 1'b1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8E1 UART receiver with 16x oversampling and frame/parity status
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           baud_select,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR,
    output logic                 Rx_VALID
);

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 sample_ENABLE;
    logic [1:0]           rxd_sync;
    logic                 rxd_s;
    rx_state_t            state;
    logic [3:0]           tick_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 p_err;

    baud_controller #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_baud_controller (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (baud_select),
        .sample_ENABLE (sample_ENABLE)
    );

    assign rxd_s = rxd_sync[1];

    // Two-flop synchronizer; preset to idle-high so reset never fakes a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_sync <= 2'b11;
        end else begin
            rxd_sync <= {rxd_sync[0], RxD};
        end
    end

    // Frame FSM: start validation at mid-bit, then one sample per bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tick_cnt  <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= '0;
            p_err     <= 1'b0;
            Rx_DATA   <= '0;
            Rx_FERROR <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_VALID  <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state    <= ST_IDLE;
                tick_cnt <= 4'd0;
                bit_idx  <= 3'd0;
            end else if (sample_ENABLE) begin
                case (state)
                    ST_IDLE: begin
                        if (!rxd_s) begin
                            state    <= ST_START;
                            tick_cnt <= 4'd0;
                        end
                    end
                    ST_START: begin
                        if (tick_cnt == MID_TICK) begin
                            tick_cnt <= 4'd0;
                            if (!rxd_s) begin
                                state     <= ST_DATA;
                                bit_idx   <= 3'd0;
                                Rx_FERROR <= 1'b0;
                                Rx_PERROR <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt           <= 4'd0;
                            shift_reg[bit_idx] <= rxd_s;
                            bit_idx            <= bit_idx + 3'd1;
                            if (bit_idx == LAST_BIT) begin
                                state <= ST_PARITY;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= 4'd0;
                            p_err    <= ^{shift_reg, rxd_s};
                            state    <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt  <= 4'd0;
                            Rx_DATA   <= shift_reg;
                            Rx_FERROR <= ~rxd_s;
                            Rx_PERROR <= p_err;
                            Rx_VALID  <= rxd_s & ~p_err;
                            state     <= ST_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        tick_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int unsigned CLK_HZ = 10_000_000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_select = 3'b111;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_FERROR;
    logic       Rx_PERROR;
    logic       Rx_VALID;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int v_mark = 0;
    int bit_clks = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_perr = 1'b0;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ_HZ (CLK_HZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_FERROR   (Rx_FERROR),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_VALID    (Rx_VALID)
    );

    // Count valid-strobe cycles and check that no error flag accompanies one.
    always @(negedge clk) begin
        if (Rx_VALID) begin
            valid_cnt++;
            n_checks++;
            assert (!(Rx_FERROR || Rx_PERROR)) else begin
                n_fail++;
                $error("FAIL valid_with_error: observed ferr=%0b perr=%0b expected both 0", Rx_FERROR, Rx_PERROR);
            end
        end
    end

    function automatic int div_of(input logic [2:0] sel);
        int rate;
        case (sel)
            3'd0:    rate = 300;
            3'd1:    rate = 1200;
            3'd2:    rate = 4800;
            3'd3:    rate = 9600;
            3'd4:    rate = 19200;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return (int'(CLK_HZ) + 8 * rate) / (16 * rate);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            RxD = bits[i];
            wait_clks(bit_clks);
        end
        RxD = 1'b1;
        wait_clks(2 * bit_clks);
    endtask

    task automatic expect_outputs(input string tag, input int pulses);
        check({tag, "_data"}, 32'(Rx_DATA), 32'(m_data));
        check({tag, "_ferr"}, 32'(Rx_FERROR), 32'(m_ferr));
        check({tag, "_perr"}, 32'(Rx_PERROR), 32'(m_perr));
        check({tag, "_pulses"}, 32'(valid_cnt - v_mark), 32'(pulses));
    endtask

    // Reference model: a received frame loads data and both flags; good frames pulse once.
    task automatic good_or_bad_frame(input string tag, input logic [7:0] d, input logic pbit, input logic sbit);
        int pulses;
        v_mark = valid_cnt;
        send_frame(d, pbit, sbit);
        m_data = d;
        m_perr = (^d) ^ pbit;
        m_ferr = ~sbit;
        pulses = (!m_perr && !m_ferr) ? 1 : 0;
        expect_outputs(tag, pulses);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        bit_clks = 16 * div_of(3'b111);

        wait_clks(3);
        v_mark = valid_cnt;
        expect_outputs("reset", 0);
        reset = 1'b1;
        wait_clks(4 * bit_clks);

        good_or_bad_frame("aa_good", 8'hAA, 1'b0, 1'b1);
        good_or_bad_frame("aa_parity", 8'hAA, 1'b1, 1'b1);
        good_or_bad_frame("x55_stop0", 8'h55, 1'b0, 1'b0);
        good_or_bad_frame("x0f_good", 8'h0F, 1'b0, 1'b1);

        v_mark = valid_cnt;
        RxD = 1'b0;
        wait_clks(5 * div_of(3'b111));
        RxD = 1'b1;
        wait_clks(2 * bit_clks);
        expect_outputs("glitch", 0);

        v_mark = valid_cnt;
        Rx_EN = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        Rx_EN = 1'b1;
        wait_clks(bit_clks);
        expect_outputs("rx_disabled", 0);

        v_mark = valid_cnt;
        RxD = 1'b0;
        wait_clks(3 * bit_clks + bit_clks / 2);
        reset = 1'b0;
        wait_clks(3);
        m_data = 8'h00;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        expect_outputs("mid_reset", 0);
        reset = 1'b1;
        RxD = 1'b1;
        wait_clks(2 * bit_clks);
        good_or_bad_frame("xc3_after_reset", 8'hC3, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            rd = 8'($urandom);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) != 0);
            good_or_bad_frame($sformatf("rand%0d", k), rd, rp, rs);
        end

        baud_select = 3'b011;
        bit_clks = 16 * div_of(3'b011);
        wait_clks(bit_clks);
        good_or_bad_frame("xa5_9600", 8'hA5, 1'b0, 1'b1);
        rd = 8'($urandom);
        good_or_bad_frame("rand_9600", rd, ^rd, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
